// File: rtl/fetch_unit.sv
// Instruction fetch for a 16-bit-word ISA: one- and two-word instructions,
// variable-latency memory handshake, stall hold, branch redirect and halt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [4:0]  HLT_OPCODE = 5'b00001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [31:0] Next_inst_addr,
    output logic [4:0]  opcode,
    output logic [2:0]  Rs,
    output logic [2:0]  Rd,
    output logic [4:0]  shmnt,
    output logic [15:0] imm,
    output logic        inst_valid
);

    typedef enum logic [1:0] {FETCH, FETCH_IMM, HALTED} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_inc;
    logic        accept, two_word;

    // First-word fields of a two-word instruction, held until its immediate arrives
    logic [4:0]  pend_op;
    logic [2:0]  pend_rs, pend_rd;
    logic [4:0]  pend_sh;

    assign pc_inc    = pc + 32'd1;
    assign imem_req  = rst_n && !stall && (state != HALTED);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready && !branch_valid;
    assign two_word  = (imem_rdata[15:14] == 2'b11);

    always_comb begin
        state_nxt = state;
        if (branch_valid) begin
            state_nxt = FETCH;
        end else if (accept) begin
            case (state)
                FETCH: begin
                    if (two_word)                             state_nxt = FETCH_IMM;
                    else if (imem_rdata[15:11] == HLT_OPCODE) state_nxt = HALTED;
                end
                FETCH_IMM: state_nxt = FETCH;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            Next_inst_addr <= 32'd0;
            opcode         <= 5'd0;
            Rs             <= 3'd0;
            Rd             <= 3'd0;
            shmnt          <= 5'd0;
            imm            <= 16'd0;
            inst_valid     <= 1'b0;
            pend_op        <= 5'd0;
            pend_rs        <= 3'd0;
            pend_rd        <= 3'd0;
            pend_sh        <= 5'd0;
        end else if (branch_valid) begin
            pc         <= branch_target;
            inst_valid <= 1'b0;
            opcode     <= 5'd0;
        end else if (accept) begin
            pc <= pc_inc;
            if (state == FETCH_IMM) begin
                opcode         <= pend_op;
                Rs             <= pend_rs;
                Rd             <= pend_rd;
                shmnt          <= pend_sh;
                imm            <= imem_rdata;
                Next_inst_addr <= pc_inc;
                inst_valid     <= 1'b1;
            end else if (two_word) begin
                pend_op    <= imem_rdata[15:11];
                pend_rs    <= imem_rdata[10:8];
                pend_rd    <= imem_rdata[7:5];
                pend_sh    <= imem_rdata[4:0];
                inst_valid <= 1'b0;
                opcode     <= 5'd0;
            end else begin
                opcode         <= imem_rdata[15:11];
                Rs             <= imem_rdata[10:8];
                Rd             <= imem_rdata[7:5];
                shmnt          <= imem_rdata[4:0];
                Next_inst_addr <= pc_inc;
                inst_valid     <= 1'b1;
            end
        end else if (!stall) begin
            // Nothing completed: NOP bubble, other fields keep their values
            inst_valid <= 1'b0;
            opcode     <= 5'd0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with programmable latency,
// expected instructions derived from memory contents and compared on inst_valid.
module tb_fetch_unit;

    localparam logic [4:0] HLT = 5'b00001;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rs, rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] nxt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [31:0] Next_inst_addr;
    logic [4:0]  opcode;
    logic [2:0]  Rs, Rd;
    logic [4:0]  shmnt;
    logic [15:0] imm;
    logic        inst_valid;

    logic [15:0] mem [0:4095];
    int          lat = 0;
    int          wait_cnt = 0;
    logic        held = 1'b0;
    logic [15:0] exp_imm = 16'd0;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .HLT_OPCODE(HLT)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Next_inst_addr(Next_inst_addr), .opcode(opcode), .Rs(Rs), .Rd(Rd),
        .shmnt(shmnt), .imm(imm), .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    assign imem_ready = (wait_cnt >= lat);
    assign imem_rdata = imem_ready ? mem[imem_addr[11:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!rst_n || branch_valid || (imem_req && imem_ready)) wait_cnt <= 0;
        else if (imem_req) wait_cnt <= wait_cnt + 1;
        held <= rst_n && stall && !branch_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_from(input logic [31:0] start, input int n);
        logic [31:0] p;
        logic [15:0] w;
        exp_t e;
        p = start;
        for (int i = 0; i < n; i++) begin
            w    = mem[p[11:0]];
            e.op = w[15:11]; e.rs = w[10:8]; e.rd = w[7:5]; e.sh = w[4:0];
            if (w[15:14] == 2'b11) begin
                p = p + 32'd1;
                exp_imm = mem[p[11:0]];
            end
            p = p + 32'd1;
            e.imm = exp_imm;
            e.nxt = p;
            sb.push_back(e);
            if (w[15:14] != 2'b11 && w[15:11] == HLT) break;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (inst_valid && !held) begin
                if (sb.size() == 0) begin
                    chk("unexpected_inst", {31'd0, inst_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("opcode", {27'd0, opcode}, {27'd0, e.op});
                    chk("Rs", {29'd0, Rs}, {29'd0, e.rs});
                    chk("Rd", {29'd0, Rd}, {29'd0, e.rd});
                    chk("shmnt", {27'd0, shmnt}, {27'd0, e.sh});
                    chk("imm", {16'd0, imm}, {16'd0, e.imm});
                    chk("next_addr", Next_inst_addr, e.nxt);
                end
            end
            if (!inst_valid) chk("nop_bubble", {27'd0, opcode}, 32'd0);
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_next"}, Next_inst_addr, 32'd0);
        chk({tag, "_fields"}, {16'd0, opcode, Rs, Rd, shmnt}, 32'd0);
        chk({tag, "_imm"}, {16'd0, imm}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[0] = 16'h2345; mem[1] = 16'h1111; mem[2] = 16'h4ABC; mem[3] = 16'h9F0F;
        mem[4] = 16'hC000; mem[5] = 16'hBEEF; mem[6] = 16'h5555; mem[7] = 16'h0800;
        mem[12'hFFF] = 16'h1234;
        mem[12'h020] = 16'h6B2D; mem[12'h021] = 16'h7F81;
        mem[12'h022] = 16'hDA5A; mem[12'h023] = 16'h1357;
        mem[12'h100] = 16'h3A5C; mem[12'h101] = 16'hC123; mem[12'h102] = 16'h4242;

        // Reset state and first request
        #1 rst_n = 1'b0;
        #1 chk_zero_outputs("reset");
        chk("reset_addr", imem_addr, 32'h0);
        exp_imm = 16'd0;
        push_from(32'h0, 16);
        repeat (2) @(negedge clk);
        chk("req_in_reset", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        #1 chk("req_after_reset", {31'd0, imem_req}, 32'd1);
        chk("addr_after_reset", imem_addr, 32'h0);

        // Straight-line program with a two-word instruction, ending in HLT
        repeat (12) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halted_req", {31'd0, imem_req}, 32'd0);
            chk("halted_pc", imem_addr, 32'h8);
        end
        chk("sb_drained_prog", sb.size(), 32'd0);

        // Redirect out of HALTED to the top of the address space: PC wraps
        push_from(32'hFFFF_FFFF, 1);
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFFF;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("wrapped_pc", imem_addr, 32'h0);

        // Redirect to 0x20 and slow memory with a stall mid-wait
        push_from(32'h20, 2);
        branch_valid = 1'b1; branch_target = 32'h20; lat = 3;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("br20_addr", imem_addr, 32'h20);
        chk("br20_req", {31'd0, imem_req}, 32'd1);
        chk("br20_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        stall = 1'b1;
        #1 chk("stall_req", {31'd0, imem_req}, 32'd0);
        chk("stall_addr", imem_addr, 32'h20);
        @(negedge clk);
        stall = 1'b0;
        #1 chk("wait_addr1", imem_addr, 32'h20);
        @(negedge clk);
        chk("wait_addr2", imem_addr, 32'h20);
        @(negedge clk);
        chk("wait_addr3", imem_addr, 32'h20);
        @(negedge clk);
        chk("slow_pc_adv", imem_addr, 32'h21);

        // Stall coinciding with ready must not accept
        lat = 0; stall = 1'b1;
        @(negedge clk);
        chk("stall_ready_hold", imem_addr, 32'h21);
        stall = 1'b0;
        @(negedge clk);
        chk("after_stall_addr", imem_addr, 32'h22);
        @(negedge clk);
        chk("fetch_imm_addr", imem_addr, 32'h23);

        // Redirect during FETCH_IMM with ready asserted drops the partial instruction
        branch_valid = 1'b1; branch_target = 32'h100;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("br100_addr", imem_addr, 32'h100);
        chk("br100_valid", {31'd0, inst_valid}, 32'd0);
        chk("br100_opcode", {27'd0, opcode}, 32'd0);
        push_from(32'h100, 1);
        @(negedge clk);
        chk("post_br_addr", imem_addr, 32'h101);
        @(negedge clk);
        chk("imm_pending_addr", imem_addr, 32'h102);

        // Asynchronous reset between edges while in FETCH_IMM
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        chk("async_reset_pc", imem_addr, 32'h0);
        chk("sb_drained_end", sb.size(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
